// File: rtl/best_tour_monitor_pkg.sv
// Shared types for the best-tour monitor: distance word, history entry, FSM states.
package best_tour_monitor_pkg;

  localparam int unsigned REPLICA_NUM = 32;
  localparam int unsigned HIST_DEPTH  = 8;
  localparam int unsigned DIS_W       = 32;
  localparam int unsigned ID_W        = $clog2(REPLICA_NUM);

  typedef logic [DIS_W-1:0] total_data_t;

  typedef struct packed {
    logic [15:0]     sweep;
    logic [ID_W-1:0] id;
    logic            chain;
    total_data_t     dis;
  } hist_entry_t;

  typedef enum logic [1:0] {
    MON_IDLE,
    MON_SCAN,
    MON_COMMIT
  } mon_state_t;

endpackage

// File: rtl/best_tour_monitor_hist_fifo.sv
// Show-ahead improvement-history FIFO; a push into a full FIFO overwrites the oldest entry.
module hist_fifo
  import best_tour_monitor_pkg::*;
#(
  parameter int unsigned depth = HIST_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  hist_entry_t              push_data,
  input  logic                     pop,
  output logic                     valid,
  output hist_entry_t              head_data,
  output logic [$clog2(depth):0]   count,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(depth);

  hist_entry_t              mem_q [depth];
  hist_entry_t              mem_d [depth];
  logic [PTR_W-1:0]         rd_q, rd_d;
  logic [PTR_W-1:0]         wr_q, wr_d;
  logic [PTR_W:0]           count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     full;
  logic                     empty;
  logic                     do_pop;

  // Pointer/count bookkeeping; when full, wr==rd so a push lands on the oldest slot.
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    full    = (count_q == (PTR_W+1)'(depth));
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
      if (do_pop || full) rd_d = rd_q + 1'b1;
      if (full && !do_pop) ovf_d = 1'b1;
      if (!do_pop && !full) count_d = count_q + 1'b1;
    end else if (do_pop) begin
      rd_d    = rd_q + 1'b1;
      count_d = count_q - 1'b1;
    end
    if (clear) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid     = (count_q != '0);
  assign head_data = mem_q[rd_q];
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/best_tour_monitor.sv
// Scans one readout sweep of both replica chains, tracks the shortest tour since clear
// and records each improvement in a small history FIFO.
module best_tour_monitor
  import best_tour_monitor_pkg::*;
#(
  parameter int unsigned replica_num = REPLICA_NUM,
  parameter int unsigned hist_depth  = HIST_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sweep_start,
  input  logic                            monitor_clear,
  input  logic                            distance_shift,
  input  total_data_t                     distance_rdata,
  output logic                            busy,
  output logic                            sweep_done,
  output logic                            improved,
  output total_data_t                     best_dis,
  output logic [$clog2(replica_num)-1:0]  best_id,
  output logic                            best_chain,
  output logic [15:0]                     best_sweep,
  input  logic                            hist_pop,
  output logic                            hist_valid,
  output hist_entry_t                     hist_data,
  output logic [$clog2(hist_depth):0]     hist_count,
  output logic                            hist_overflow
);

  localparam int unsigned CNT_W = $clog2(2*replica_num);
  localparam int unsigned IDW   = $clog2(replica_num);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(2*replica_num - 1);

  mon_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  total_data_t       smin_q, smin_d;
  logic [IDW-1:0]    sidx_q, sidx_d;
  logic              schain_q, schain_d;
  total_data_t       best_dis_q, best_dis_d;
  logic [IDW-1:0]    best_id_q, best_id_d;
  logic              best_chain_q, best_chain_d;
  logic [15:0]       best_sweep_q, best_sweep_d;
  logic [15:0]       sweep_no_q, sweep_no_d;
  logic              push;
  hist_entry_t       push_entry;

  // Next-state, scan compare and commit; monitor_clear overrides everything last.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    smin_d       = smin_q;
    sidx_d       = sidx_q;
    schain_d     = schain_q;
    best_dis_d   = best_dis_q;
    best_id_d    = best_id_q;
    best_chain_d = best_chain_q;
    best_sweep_d = best_sweep_q;
    sweep_no_d   = sweep_no_q;
    sweep_done   = 1'b0;
    improved     = 1'b0;
    push         = 1'b0;
    unique case (state_q)
      MON_IDLE: begin
        if (sweep_start) begin
          state_d  = MON_SCAN;
          cnt_d    = '0;
          smin_d   = '1;
          sidx_d   = '0;
          schain_d = 1'b0;
        end
      end
      MON_SCAN: begin
        if (sweep_start) begin
          cnt_d    = '0;
          smin_d   = '1;
          sidx_d   = '0;
          schain_d = 1'b0;
        end else if (distance_shift) begin
          if (distance_rdata < smin_q) begin
            smin_d   = distance_rdata;
            sidx_d   = cnt_q[CNT_W-1:1];
            schain_d = cnt_q[0];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) state_d = MON_COMMIT;
        end
      end
      MON_COMMIT: begin
        sweep_done = 1'b1;
        if (smin_q < best_dis_q) begin
          best_dis_d   = smin_q;
          best_id_d    = sidx_q;
          best_chain_d = schain_q;
          best_sweep_d = sweep_no_q;
          improved     = 1'b1;
          push         = 1'b1;
        end
        sweep_no_d = sweep_no_q + 1'b1;
        state_d    = MON_IDLE;
      end
      default: state_d = MON_IDLE;
    endcase
    if (monitor_clear) begin
      state_d      = MON_IDLE;
      best_dis_d   = '1;
      best_id_d    = '0;
      best_chain_d = 1'b0;
      best_sweep_d = '0;
      sweep_no_d   = '0;
      sweep_done   = 1'b0;
      improved     = 1'b0;
      push         = 1'b0;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= MON_IDLE;
      cnt_q        <= '0;
      smin_q       <= '1;
      sidx_q       <= '0;
      schain_q     <= 1'b0;
      best_dis_q   <= '1;
      best_id_q    <= '0;
      best_chain_q <= 1'b0;
      best_sweep_q <= '0;
      sweep_no_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      smin_q       <= smin_d;
      sidx_q       <= sidx_d;
      schain_q     <= schain_d;
      best_dis_q   <= best_dis_d;
      best_id_q    <= best_id_d;
      best_chain_q <= best_chain_d;
      best_sweep_q <= best_sweep_d;
      sweep_no_q   <= sweep_no_d;
    end
  end

  assign push_entry = '{sweep: sweep_no_q, id: ID_W'(sidx_q), chain: schain_q, dis: smin_q};

  hist_fifo #(
    .depth (hist_depth)
  ) u_hist_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (monitor_clear),
    .push      (push),
    .push_data (push_entry),
    .pop       (hist_pop),
    .valid     (hist_valid),
    .head_data (hist_data),
    .count     (hist_count),
    .overflow  (hist_overflow)
  );

  assign busy       = (state_q != MON_IDLE);
  assign best_dis   = best_dis_q;
  assign best_id    = best_id_q;
  assign best_chain = best_chain_q;
  assign best_sweep = best_sweep_q;

endmodule

// File: tb/tb_best_tour_monitor.sv
// Self-checking bench for best_tour_monitor: vector table, corner sequences, random sweeps.
module tb_best_tour_monitor;
  import best_tour_monitor_pkg::*;

  localparam int NW = 2 * REPLICA_NUM;
  localparam total_data_t MAXD = '1;

  logic                   clk;
  logic                   reset;
  logic                   sweep_start;
  logic                   monitor_clear;
  logic                   distance_shift;
  total_data_t            distance_rdata;
  logic                   busy;
  logic                   sweep_done;
  logic                   improved;
  total_data_t            best_dis;
  logic [ID_W-1:0]        best_id;
  logic                   best_chain;
  logic [15:0]            best_sweep;
  logic                   hist_pop;
  logic                   hist_valid;
  hist_entry_t            hist_data;
  logic [$clog2(HIST_DEPTH):0] hist_count;
  logic                   hist_overflow;

  best_tour_monitor #(
    .replica_num (REPLICA_NUM),
    .hist_depth  (HIST_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sweep_start    (sweep_start),
    .monitor_clear  (monitor_clear),
    .distance_shift (distance_shift),
    .distance_rdata (distance_rdata),
    .busy           (busy),
    .sweep_done     (sweep_done),
    .improved       (improved),
    .best_dis       (best_dis),
    .best_id        (best_id),
    .best_chain     (best_chain),
    .best_sweep     (best_sweep),
    .hist_pop       (hist_pop),
    .hist_valid     (hist_valid),
    .hist_data      (hist_data),
    .hist_count     (hist_count),
    .hist_overflow  (hist_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  always @(posedge clk) if (sweep_done === 1'b1) done_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  total_data_t words [NW];

  // ---------------- reference model ----------------
  total_data_t m_best;
  int          m_id;
  int          m_chain;
  int          m_bsweep;
  int          m_sweep_no;
  hist_entry_t mq[$];
  bit          m_ovf;

  task automatic model_clear();
    m_best = MAXD; m_id = 0; m_chain = 0; m_bsweep = 0; m_sweep_no = 0;
    mq.delete(); m_ovf = 1'b0;
  endtask

  task automatic model_sweep(input bit pop, output bit imp);
    total_data_t mn;
    int idx;
    hist_entry_t e;
    mn = MAXD;
    idx = 0;
    for (int k = 0; k < NW; k++) if (words[k] < mn) mn = words[k];
    for (int k = NW - 1; k >= 0; k--) if (words[k] == mn) idx = k;
    imp = (mn < m_best);
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (imp) begin
      m_best = mn; m_id = idx / 2; m_chain = idx % 2; m_bsweep = m_sweep_no;
      e.sweep = 16'(m_sweep_no); e.id = ID_W'(idx / 2); e.chain = 1'(idx % 2); e.dis = mn;
      mq.push_back(e);
      if (mq.size() > HIST_DEPTH) begin
        void'(mq.pop_front());
        m_ovf = 1'b1;
      end
    end
    m_sweep_no = (m_sweep_no + 1) % 65536;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".best_dis"},   64'(best_dis),      64'(m_best));
    chk({tag, ".best_id"},    64'(best_id),       64'(m_id));
    chk({tag, ".best_chain"}, 64'(best_chain),    64'(m_chain));
    chk({tag, ".best_sweep"}, 64'(best_sweep),    64'(m_bsweep));
    chk({tag, ".hist_count"}, 64'(hist_count),    64'(mq.size()));
    chk({tag, ".hist_valid"}, 64'(hist_valid),    64'(mq.size() > 0));
    chk({tag, ".overflow"},   64'(hist_overflow), 64'(m_ovf));
    if (mq.size() > 0) chk({tag, ".hist_data"}, 64'(hist_data), 64'(mq[0]));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_clear();
    monitor_clear = 1'b1; step(); monitor_clear = 1'b0;
  endtask

  task automatic fill(input total_data_t v);
    for (int k = 0; k < NW; k++) words[k] = v;
  endtask

  // Arms a sweep, shifts all words, samples the COMMIT-cycle pulses, then lets best update.
  task automatic send_sweep(input bit pop_in_commit, output bit got_done, output bit got_imp);
    sweep_start = 1'b1; step(); sweep_start = 1'b0;
    for (int k = 0; k < NW; k++) begin
      distance_shift = 1'b1; distance_rdata = words[k]; step();
    end
    distance_shift = 1'b0;
    hist_pop = pop_in_commit;
    #1;
    got_done = sweep_done;
    got_imp  = improved;
    step();
    hist_pop = 1'b0;
  endtask

  typedef struct {
    bit          clr;
    total_data_t base;
    int          k1;
    total_data_t v1;
    int          k2;
    total_data_t v2;
    bit          e_imp;
    total_data_t e_dis;
    int          e_id;
    int          e_chain;
    int          e_sweep;
    int          e_cnt;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit d, im, pc;
    int d0;
    int npop;
    int top;

    vecs[0] = '{1'b1, 500, 11, 100, -1, 0,  1'b1, 100,  5,  1, 0, 1};
    vecs[1] = '{1'b0, 500, 20, 150, -1, 0,  1'b0, 100,  5,  1, 0, 1};
    vecs[2] = '{1'b1, 500,  3,  50, 40, 50, 1'b1,  50,  1,  1, 0, 1};
    vecs[3] = '{1'b0, 500,  0,  49, -1, 0,  1'b1,  49,  0,  0, 1, 2};
    vecs[4] = '{1'b1, MAXD, -1,  0, -1, 0,  1'b0, MAXD, 0,  0, 0, 0};
    vecs[5] = '{1'b0, 500, 63,   7, -1, 0,  1'b1,   7, 31,  1, 1, 1};
    vecs[6] = '{1'b0,   7, -1,   0, -1, 0,  1'b0,   7, 31,  1, 1, 1};

    reset = 1'b1; sweep_start = 1'b0; monitor_clear = 1'b0;
    distance_shift = 1'b0; distance_rdata = '0; hist_pop = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst.busy",       64'(busy),          64'd0);
    chk("rst.sweep_done", 64'(sweep_done),    64'd0);
    chk("rst.improved",   64'(improved),      64'd0);
    chk("rst.best_dis",   64'(best_dis),      64'(MAXD));
    chk("rst.best_id",    64'(best_id),       64'd0);
    chk("rst.best_sweep", 64'(best_sweep),    64'd0);
    chk("rst.hist_valid", 64'(hist_valid),    64'd0);
    chk("rst.hist_count", 64'(hist_count),    64'd0);
    chk("rst.overflow",   64'(hist_overflow), 64'd0);

    // Table-driven sweeps.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].clr) do_clear();
      fill(vecs[i].base);
      if (vecs[i].k1 >= 0) words[vecs[i].k1] = vecs[i].v1;
      if (vecs[i].k2 >= 0) words[vecs[i].k2] = vecs[i].v2;
      send_sweep(1'b0, d, im);
      chk($sformatf("vec%0d.sweep_done", i), 64'(d),          64'd1);
      chk($sformatf("vec%0d.improved", i),   64'(im),         64'(vecs[i].e_imp));
      chk($sformatf("vec%0d.best_dis", i),   64'(best_dis),   64'(vecs[i].e_dis));
      chk($sformatf("vec%0d.best_id", i),    64'(best_id),    64'(vecs[i].e_id));
      chk($sformatf("vec%0d.best_chain", i), 64'(best_chain), 64'(vecs[i].e_chain));
      chk($sformatf("vec%0d.best_sweep", i), 64'(best_sweep), 64'(vecs[i].e_sweep));
      chk($sformatf("vec%0d.hist_count", i), 64'(hist_count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.busy", i),       64'(busy),       64'd0);
    end

    // Ten strictly improving sweeps overflow the eight-deep history.
    do_clear();
    for (int i = 0; i < 10; i++) begin
      fill(total_data_t'(900 - 100 * i));
      send_sweep(1'b0, d, im);
      chk($sformatf("impr%0d.improved", i), 64'(im), 64'd1);
    end
    chk("impr.hist_count", 64'(hist_count),      64'd8);
    chk("impr.overflow",   64'(hist_overflow),   64'd1);
    chk("impr.head_sweep", 64'(hist_data.sweep), 64'd2);
    chk("impr.head_dis",   64'(hist_data.dis),   64'd700);
    chk("impr.best_sweep", 64'(best_sweep),      64'd9);
    hist_pop = 1'b1; step(); hist_pop = 1'b0;
    chk("impr.pop_sweep",  64'(hist_data.sweep), 64'd3);
    chk("impr.pop_dis",    64'(hist_data.dis),   64'd600);
    chk("impr.pop_count",  64'(hist_count),      64'd7);

    // Reset mid-scan discards the sweep and all history.
    sweep_start = 1'b1; step(); sweep_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      distance_shift = 1'b1; distance_rdata = 1; step();
    end
    reset = 1'b1; step(); reset = 1'b0; distance_shift = 1'b0;
    #1;
    chk("rmid.busy",       64'(busy),          64'd0);
    chk("rmid.best_dis",   64'(best_dis),      64'(MAXD));
    chk("rmid.best_id",    64'(best_id),       64'd0);
    chk("rmid.best_chain", 64'(best_chain),    64'd0);
    chk("rmid.best_sweep", 64'(best_sweep),    64'd0);
    chk("rmid.hist_count", 64'(hist_count),    64'd0);
    chk("rmid.overflow",   64'(hist_overflow), 64'd0);
    chk("rmid.sweep_done", 64'(sweep_done),    64'd0);

    // Restart after 20 shifts: only the later 64 words count, one sweep_done.
    do_clear();
    d0 = done_cnt;
    sweep_start = 1'b1; step(); sweep_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      distance_shift = 1'b1; distance_rdata = 1; step();
    end
    distance_shift = 1'b0; sweep_start = 1'b1; step(); sweep_start = 1'b0;
    for (int k = 0; k < NW; k++) begin
      distance_shift = 1'b1; distance_rdata = (k == 9) ? 200 : 300; step();
    end
    distance_shift = 1'b0;
    step(); step();
    chk("restart.done_count", 64'(done_cnt - d0), 64'd1);
    chk("restart.best_dis",   64'(best_dis),       64'd200);
    chk("restart.best_id",    64'(best_id),        64'd4);
    chk("restart.best_chain", 64'(best_chain),     64'd1);

    // monitor_clear in the middle of SCAN.
    sweep_start = 1'b1; step(); sweep_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      distance_shift = 1'b1; distance_rdata = 5; step();
    end
    monitor_clear = 1'b1; step(); monitor_clear = 1'b0; distance_shift = 1'b0;
    chk("clrscan.busy",       64'(busy),       64'd0);
    chk("clrscan.best_dis",   64'(best_dis),   64'(MAXD));
    chk("clrscan.hist_valid", 64'(hist_valid), 64'd0);

    // monitor_clear in COMMIT suppresses pulses and the push.
    sweep_start = 1'b1; step(); sweep_start = 1'b0;
    for (int k = 0; k < NW; k++) begin
      distance_shift = 1'b1; distance_rdata = 10; step();
    end
    distance_shift = 1'b0; monitor_clear = 1'b1;
    #1;
    chk("clrcommit.sweep_done", 64'(sweep_done), 64'd0);
    chk("clrcommit.improved",   64'(improved),   64'd0);
    step(); monitor_clear = 1'b0;
    chk("clrcommit.best_dis",   64'(best_dis),   64'(MAXD));
    chk("clrcommit.hist_count", 64'(hist_count), 64'd0);

    // Simultaneous clear and start: sweep is not armed.
    monitor_clear = 1'b1; sweep_start = 1'b1; step();
    monitor_clear = 1'b0; sweep_start = 1'b0;
    chk("clrstart.busy", 64'(busy), 64'd0);

    // Shifts while IDLE are ignored.
    fill(300);
    send_sweep(1'b0, d, im);
    d0 = done_cnt;
    for (int k = 0; k < 5; k++) begin
      distance_shift = 1'b1; distance_rdata = 0; step();
    end
    distance_shift = 1'b0; step();
    chk("idle.busy",       64'(busy),           64'd0);
    chk("idle.done_count", 64'(done_cnt - d0),  64'd0);
    chk("idle.best_dis",   64'(best_dis),       64'd300);

    // Randomized sweeps against the model, including pops during COMMIT and while empty.
    do_clear();
    model_clear();
    for (int s = 0; s < 40; s++) begin
      top = 3000 - 70 * s;
      for (int k = 0; k < NW; k++) words[k] = total_data_t'($urandom_range(top, 40));
      if ($urandom_range(0, 7) == 0) fill(MAXD);
      pc = ($urandom_range(0, 3) == 0);
      send_sweep(pc, d, im);
      model_sweep(pc, pc);
      chk($sformatf("rnd%0d.sweep_done", s), 64'(d),  64'd1);
      chk($sformatf("rnd%0d.improved", s),   64'(im), 64'(pc));
      check_model($sformatf("rnd%0d", s));
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        hist_pop = 1'b1; step(); hist_pop = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if (npop > 0) check_model($sformatf("rnd%0d.pop", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
